// File: rtl/hdd_sector_server_if.sv
// rtl/hdd_sector_server_if.sv - card, sector buffer and block storage signals of hdd_sector_server
// master is the sector server; slave is the card/buffer/storage side.
interface hdd_sector_server_if;
  logic        img_mounted;
  logic        img_readonly;
  logic        hdd_mounted;
  logic        hdd_protect;
  logic [15:0] hdd_sector;
  logic        hdd_read;
  logic        hdd_write;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;
  logic        ram_we;
  logic [31:0] blk_lba;
  logic        blk_rd;
  logic        blk_wr;
  logic        blk_ack;
  logic [7:0]  blk_rd_data;
  logic        blk_rd_valid;
  logic [7:0]  blk_wr_data;
  logic        blk_wr_valid;
  logic        blk_wr_ready;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  img_mounted, img_readonly, hdd_sector, hdd_read, hdd_write, ram_do,
           blk_ack, blk_rd_data, blk_rd_valid, blk_wr_ready,
    output hdd_mounted, hdd_protect, ram_addr, ram_di, ram_we, blk_lba, blk_rd,
           blk_wr, blk_wr_data, blk_wr_valid, busy, done, err
  );

  modport slave (
    output img_mounted, img_readonly, hdd_sector, hdd_read, hdd_write, ram_do,
           blk_ack, blk_rd_data, blk_rd_valid, blk_wr_ready,
    input  hdd_mounted, hdd_protect, ram_addr, ram_di, ram_we, blk_lba, blk_rd,
           blk_wr, blk_wr_data, blk_wr_valid, busy, done, err
  );
endinterface

// File: rtl/hdd_sector_server.sv
// rtl/hdd_sector_server.sv - moves one 512-byte sector between the HDD card buffer and block storage
// Requests are rising edges of hdd_read/hdd_write; read wins when both rise together.
module hdd_sector_server #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input logic                 clk_sys,
  input logic                 reset_n,
  hdd_sector_server_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_FETCH,
    S_WR_SEND,
    S_FINISH
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rd_q;
  logic        r_rd_q2;
  logic        r_wr_q;
  logic        r_wr_q2;
  logic        r_mounted;
  logic        r_protect;
  logic [15:0] r_sector;
  logic [9:0]  r_cnt;
  logic [23:0] r_tmo;
  logic        r_fetch_ph;
  logic [8:0]  r_ram_addr;
  logic [7:0]  r_ram_di;
  logic        r_ram_we;
  logic [7:0]  r_wr_data;
  logic        r_wr_valid;
  logic        r_err;

  logic        w_rd_edge;
  logic        w_wr_edge;
  logic        w_accept;
  logic        w_tmo_hit;
  logic        w_abort;
  logic        w_set_err;

  assign w_rd_edge = r_rd_q & ~r_rd_q2;
  assign w_wr_edge = r_wr_q & ~r_wr_q2;
  assign w_accept  = (r_state == S_IDLE) & bus.img_mounted & (w_rd_edge | w_wr_edge);
  assign w_tmo_hit = (r_tmo == TIMEOUT_CYCLES - 24'd1);
  // Losing the image aborts anything in flight; FINISH is already on its way out.
  assign w_abort   = (r_state != S_IDLE) && (r_state != S_FINISH) && !bus.img_mounted;

  always_comb begin
    w_state_nxt = r_state;
    w_set_err   = 1'b0;
    if ((r_state != S_IDLE) && (w_rd_edge || w_wr_edge)) begin
      w_set_err = 1'b1;
    end
    if (w_abort) begin
      w_state_nxt = S_FINISH;
      w_set_err   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_rd_edge) begin
              w_state_nxt = S_RD_REQ;
            end else if (bus.img_readonly) begin
              w_state_nxt = S_FINISH;
              w_set_err   = 1'b1;
            end else begin
              w_state_nxt = S_WR_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (bus.blk_ack) begin
            w_state_nxt = S_RD_DATA;
          end else if (w_tmo_hit) begin
            w_state_nxt = S_FINISH;
            w_set_err   = 1'b1;
          end
        end
        S_RD_DATA: begin
          if (bus.blk_rd_valid && (r_cnt == 10'd511)) begin
            w_state_nxt = S_FINISH;
          end
        end
        S_WR_REQ: begin
          if (bus.blk_ack) begin
            w_state_nxt = S_WR_FETCH;
          end else if (w_tmo_hit) begin
            w_state_nxt = S_FINISH;
            w_set_err   = 1'b1;
          end
        end
        S_WR_FETCH: begin
          if (r_fetch_ph) begin
            w_state_nxt = S_WR_SEND;
          end
        end
        S_WR_SEND: begin
          if (bus.blk_wr_ready) begin
            w_state_nxt = (r_cnt == 10'd511) ? S_FINISH : S_WR_FETCH;
          end
        end
        S_FINISH: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rd_q     <= 1'b0;
      r_rd_q2    <= 1'b0;
      r_wr_q     <= 1'b0;
      r_wr_q2    <= 1'b0;
      r_mounted  <= 1'b0;
      r_protect  <= 1'b0;
      r_sector   <= 16'h0;
      r_cnt      <= 10'd0;
      r_tmo      <= 24'd0;
      r_fetch_ph <= 1'b0;
      r_ram_addr <= 9'd0;
      r_ram_di   <= 8'h0;
      r_ram_we   <= 1'b0;
      r_wr_data  <= 8'h0;
      r_wr_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_q    <= bus.hdd_read;
      r_rd_q2   <= r_rd_q;
      r_wr_q    <= bus.hdd_write;
      r_wr_q2   <= r_wr_q;
      r_mounted <= bus.img_mounted;
      r_protect <= bus.img_readonly;
      r_ram_we  <= 1'b0;

      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (w_accept) begin
        r_err <= 1'b0;
      end

      if (w_accept) begin
        r_sector <= bus.hdd_sector;
        r_cnt    <= 10'd0;
      end

      if ((r_state == S_RD_REQ) || (r_state == S_WR_REQ)) begin
        r_tmo <= r_tmo + 24'd1;
      end else begin
        r_tmo <= 24'd0;
      end

      if (w_abort) begin
        r_wr_valid <= 1'b0;
        r_fetch_ph <= 1'b0;
      end else begin
        case (r_state)
          S_RD_DATA: begin
            if (bus.blk_rd_valid) begin
              r_ram_we   <= 1'b1;
              r_ram_addr <= r_cnt[8:0];
              r_ram_di   <= bus.blk_rd_data;
              r_cnt      <= r_cnt + 10'd1;
            end
          end
          S_WR_REQ: begin
            if (bus.blk_ack) begin
              r_ram_addr <= r_cnt[8:0];
            end
          end
          // Two cycles here: address out, then the buffer's registered byte is captured.
          S_WR_FETCH: begin
            if (!r_fetch_ph) begin
              r_fetch_ph <= 1'b1;
            end else begin
              r_fetch_ph <= 1'b0;
              r_wr_data  <= bus.ram_do;
              r_wr_valid <= 1'b1;
            end
          end
          S_WR_SEND: begin
            if (bus.blk_wr_ready) begin
              r_wr_valid <= 1'b0;
              r_cnt      <= r_cnt + 10'd1;
              r_ram_addr <= r_cnt[8:0] + 9'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.hdd_mounted  = r_mounted;
  assign bus.hdd_protect  = r_protect;
  assign bus.ram_addr     = r_ram_addr;
  assign bus.ram_di       = r_ram_di;
  assign bus.ram_we       = r_ram_we;
  assign bus.blk_lba      = {16'h0, r_sector};
  assign bus.blk_rd       = (r_state == S_RD_REQ);
  assign bus.blk_wr       = (r_state == S_WR_REQ);
  assign bus.blk_wr_data  = r_wr_data;
  assign bus.blk_wr_valid = r_wr_valid;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = (r_state == S_FINISH);
  assign bus.err          = r_err;

endmodule

// File: tb/tb_hdd_sector_server.sv
// tb/tb_hdd_sector_server.sv - directed bench for hdd_sector_server
module tb_hdd_sector_server;

  logic clk;
  logic rst_n;
  hdd_sector_server_if bus();

  hdd_sector_server #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk_sys (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:511];
  always @(posedge clk) bus.ram_do <= mem[bus.ram_addr];

  int checks   = 0;
  int failures = 0;
  int we_cnt;
  int we_bad;
  int done_cnt;
  bit saw_wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {14'h0, bus.ram_addr, bus.ram_di, bus.ram_we, bus.blk_lba[15:0], bus.blk_rd,
            bus.blk_wr, bus.blk_wr_data, bus.blk_wr_valid, bus.busy, bus.done, bus.err,
            bus.hdd_mounted, bus.hdd_protect};
  endfunction

  // Every read stream below sends byte k = k[7:0], so buffer writes must carry addr == index, data == addr low byte.
  task automatic tick();
    @(negedge clk);
    if (bus.ram_we) begin
      if (bus.ram_addr != we_cnt[8:0] || bus.ram_di != we_cnt[7:0]) we_bad++;
      we_cnt++;
    end
    if (bus.done) done_cnt++;
    if (bus.blk_wr) saw_wr = 1'b1;
  endtask

  // kind: 0 none, 1 extra read edge, 2 unmount, 3 reset pulse; applied at stream byte 'at'
  task automatic run_read(input logic [15:0] sec, input bit both, input int nbytes,
                          input int kind, input int at,
                          output bit lat_ok, output bit fb_ok, output logic [63:0] rst_vec);
    we_cnt = 0; we_bad = 0; done_cnt = 0; saw_wr = 1'b0;
    fb_ok = 1'b0; rst_vec = '1;
    bus.hdd_sector = sec;
    bus.hdd_read   = 1'b1;
    bus.hdd_write  = both;
    tick();
    bus.hdd_read  = 1'b0;
    bus.hdd_write = 1'b0;
    tick();
    lat_ok = bus.blk_rd && bus.busy && !bus.blk_wr;
    tick();
    tick();
    bus.blk_ack = 1'b1;
    tick();
    bus.blk_ack = 1'b0;
    for (int k = 0; k < nbytes; k++) begin
      if (kind == 3) rst_n = !(k >= at && k < at + 2);
      if (kind == 2) bus.img_mounted = !(k >= at);
      bus.hdd_read     = (kind == 1 && k == at);
      bus.blk_rd_data  = 8'(k);
      bus.blk_rd_valid = 1'b1;
      tick();
      if (k == 0) fb_ok = bus.ram_we && (bus.ram_addr == 9'd0);
      if (kind == 3 && k == at) rst_vec = out_vec();
    end
    bus.blk_rd_valid = 1'b0;
    bus.hdd_read     = 1'b0;
    rst_n            = 1'b1;
    bus.img_mounted  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  bit          lat_ok;
  bit          fb_ok;
  logic [63:0] rst_vec;
  int          n;
  int          hs;
  int          hs_bad;
  bit          d1;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
    rst_n = 1'b0;
    bus.img_mounted = 1'b0; bus.img_readonly = 1'b0; bus.hdd_sector = 16'h0;
    bus.hdd_read = 1'b0; bus.hdd_write = 1'b0; bus.blk_ack = 1'b0;
    bus.blk_rd_data = 8'h0; bus.blk_rd_valid = 1'b0; bus.blk_wr_ready = 1'b0;
    we_cnt = 0; we_bad = 0; done_cnt = 0; saw_wr = 1'b0;
    bus.img_mounted = 1'b1;
    tick(); tick(); tick();
    check("reset_outputs", out_vec(), 64'h0);
    rst_n = 1'b1;
    bus.img_mounted = 1'b0;
    tick();
    bus.img_mounted = 1'b1;
    check("mounted_lag_before", bus.hdd_mounted, 1'b0);
    tick();
    check("mounted_lag_after", bus.hdd_mounted, 1'b1);

    // Read sector 5 with 4 surplus bytes after the sector
    run_read(16'd5, 1'b0, 516, 0, 0, lat_ok, fb_ok, rst_vec);
    check("rd5_start_latency", lat_ok, 1'b1);
    check("rd5_byte_latency", fb_ok, 1'b1);
    check("rd5_we_count", we_cnt, 512);
    check("rd5_we_bad", we_bad, 0);
    check("rd5_done", done_cnt, 1);
    check("rd5_err", bus.err, 1'b0);
    check("rd5_lba", bus.blk_lba, 32'd5);
    check("rd5_busy", bus.busy, 1'b0);

    // Write sector 0x1234 with throttled ready
    done_cnt = 0; saw_wr = 1'b0; hs = 0; hs_bad = 0;
    bus.hdd_sector = 16'h1234;
    bus.hdd_write  = 1'b1;
    tick();
    bus.hdd_write = 1'b0;
    for (int i = 0; i < 20 && !bus.blk_wr; i++) tick();
    check("wr_req", bus.blk_wr, 1'b1);
    tick();
    bus.blk_ack = 1'b1;
    tick();
    bus.blk_ack = 1'b0;
    for (int c = 0; c < 8000 && done_cnt == 0; c++) begin
      bus.blk_wr_ready = ($urandom_range(0, 2) != 0);
      if (bus.blk_wr_valid && bus.blk_wr_ready) begin
        if (bus.blk_wr_data != (8'(hs) ^ 8'hA5)) hs_bad++;
        hs++;
      end
      tick();
    end
    bus.blk_wr_ready = 1'b0;
    tick(); tick();
    check("wr_handshakes", hs, 512);
    check("wr_data_bad", hs_bad, 0);
    check("wr_done", done_cnt, 1);
    check("wr_lba", bus.blk_lba, 32'h1234);
    check("wr_err", bus.err, 1'b0);

    // Protected write
    bus.img_readonly = 1'b1;
    tick();
    done_cnt = 0; saw_wr = 1'b0;
    check("prot_mirror", bus.hdd_protect, 1'b1);
    bus.hdd_write = 1'b1;
    tick();
    d1 = bus.done;
    bus.hdd_write = 1'b0;
    tick();
    check("prot_done_early", d1, 1'b0);
    check("prot_done_at_2", bus.done, 1'b1);
    check("prot_err", bus.err, 1'b1);
    tick(); tick();
    check("prot_no_blk_wr", saw_wr, 1'b0);
    check("prot_done_count", done_cnt, 1);
    bus.img_readonly = 1'b0;
    tick();

    // Timeout with no ack
    done_cnt = 0;
    bus.hdd_sector = 16'd7;
    bus.hdd_read   = 1'b1;
    tick();
    bus.hdd_read = 1'b0;
    tick();
    n = 0;
    for (int i = 0; i < 100 && bus.blk_rd; i++) begin
      n++;
      tick();
    end
    tick(); tick();
    check("tmo_rd_cycles", n, 16);
    check("tmo_done", done_cnt, 1);
    check("tmo_err", bus.err, 1'b1);

    run_read(16'd9, 1'b0, 512, 0, 0, lat_ok, fb_ok, rst_vec);
    check("tmo_next_we", we_cnt, 512);
    check("tmo_next_err_clear", bus.err, 1'b0);

    // Second read edge while busy
    run_read(16'd10, 1'b0, 512, 1, 50, lat_ok, fb_ok, rst_vec);
    check("busy_edge_we", we_cnt, 512);
    check("busy_edge_done", done_cnt, 1);
    check("busy_edge_err", bus.err, 1'b1);

    // Read and write rising together
    run_read(16'd11, 1'b1, 512, 0, 0, lat_ok, fb_ok, rst_vec);
    check("coll_read_started", lat_ok, 1'b1);
    check("coll_no_write", saw_wr, 1'b0);
    check("coll_we", we_cnt, 512);
    check("coll_done", done_cnt, 1);
    check("coll_err", bus.err, 1'b0);

    // Unmount after 100 bytes
    run_read(16'd12, 1'b0, 200, 2, 100, lat_ok, fb_ok, rst_vec);
    check("unmount_we", we_cnt, 100);
    check("unmount_done", done_cnt, 1);
    check("unmount_err", bus.err, 1'b1);

    // Reset pulse after 100 bytes
    run_read(16'd13, 1'b0, 200, 3, 100, lat_ok, fb_ok, rst_vec);
    check("rst_mid_outputs", rst_vec, 64'h0);
    check("rst_mid_we", we_cnt, 100);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_idle", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
